// File: rtl/zero_out_pkg.sv
// Shared types and constants for the Zero engine out-channel checker.
package zero_out_pkg;

    localparam int MEMORY_ELEMENT_WIDTH = 12;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} zero_out_state_t;

    // Element counter that sticks at its maximum instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/zero_out_fifo.sv
// First-word fall-through FIFO with an occupancy counter; head reads as zero while empty.
module zero_out_fifo
    import zero_out_pkg::*;
#(
    parameter int Width = MEMORY_ELEMENT_WIDTH,
    parameter int Depth = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    output logic [Width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(Depth);

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [Width-1:0] mem [Depth];
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_reg == (AW+1)'(Depth));
    assign empty = (count_reg == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/zero_out_checker.sv
// Out-channel sink stage: buffers engine results, forwards them downstream and
// checks every drained element against a loadable expected-value table.
module zero_out_checker
    import zero_out_pkg::*;
#(
    parameter int MemoryElementWidth = MEMORY_ELEMENT_WIDTH,
    parameter int NOut               = 16,
    parameter int NExpect            = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             exp_we,
    input  logic [$clog2(NExpect)-1:0]       exp_addr,
    input  logic [MemoryElementWidth-1:0]    exp_data,
    input  logic [$clog2(NExpect+1)-1:0]     exp_count,
    input  logic                             out_valid,
    input  logic [MemoryElementWidth-1:0]    out_data,
    output logic                             out_ready,
    input  logic                             prog_done,
    output logic                             sink_valid,
    output logic [MemoryElementWidth-1:0]    sink_data,
    input  logic                             sink_ready,
    output logic [15:0]                      drained,
    output logic                             dropped,
    output logic                             finished,
    output logic                             success
);

    localparam int EW = $clog2(NExpect);
    localparam int CW = $clog2(NExpect + 1);

    zero_out_state_t state_reg, state_next;

    logic [MemoryElementWidth-1:0] exp_table [NExpect];
    logic [MemoryElementWidth-1:0] fifo_head;
    logic [CW-1:0]                 exp_count_q_reg;
    logic [15:0]                   drained_reg;
    logic                          mismatch_reg;
    logic                          dropped_reg;
    logic                          finished_reg;
    logic                          success_reg;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          start_run;
    logic                          active;
    logic                          table_open;
    logic                          wr_en;
    logic                          rd_en;
    logic                          drop_now;
    logic                          compare_bad;

    always_comb begin
        state_next = state_reg;
        start_run  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    start_run  = 1'b1;
                end
            end
            RUN:     if (prog_done) state_next = DRAIN;
            DRAIN:   if (fifo_empty) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    assign active     = (state_reg == RUN) || (state_reg == DRAIN);
    assign table_open = (state_reg == IDLE) || (state_reg == DONE);
    assign out_ready  = (state_reg == RUN) && !fifo_full;
    assign wr_en      = out_valid && out_ready;
    assign sink_valid = active && !fifo_empty;
    assign rd_en      = sink_valid && sink_ready;
    assign sink_data  = fifo_head;
    assign drop_now   = active && out_valid && !out_ready;

    // Index is the pre-increment drained count; out-of-range indices are caught by the first term.
    assign compare_bad = (32'(drained_reg) >= 32'(exp_count_q_reg)) ||
                         (fifo_head != exp_table[drained_reg[EW-1:0]]);

    zero_out_fifo #(
        .Width (MemoryElementWidth),
        .Depth (NOut)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (start_run),
        .wr_en   (wr_en),
        .wr_data (out_data),
        .rd_en   (rd_en),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The table has no reset so it survives a mid-run reset.
    always_ff @(posedge clock) begin
        if (exp_we && table_open) exp_table[exp_addr] <= exp_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            exp_count_q_reg <= '0;
            drained_reg     <= '0;
            mismatch_reg    <= 1'b0;
            dropped_reg     <= 1'b0;
            finished_reg    <= 1'b0;
            success_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_run) begin
                exp_count_q_reg <= exp_count;
                drained_reg     <= '0;
                mismatch_reg    <= 1'b0;
                dropped_reg     <= 1'b0;
                finished_reg    <= 1'b0;
                success_reg     <= 1'b0;
            end else begin
                if (rd_en) begin
                    drained_reg <= sat_inc16(drained_reg);
                    if (compare_bad) mismatch_reg <= 1'b1;
                end
                if (drop_now) dropped_reg <= 1'b1;
                if (state_reg == DRAIN && state_next == DONE) begin
                    finished_reg <= 1'b1;
                    success_reg  <= !mismatch_reg && !dropped_reg && !drop_now &&
                                    (32'(drained_reg) == 32'(exp_count_q_reg));
                end
            end
        end
    end

    assign drained  = drained_reg;
    assign dropped  = dropped_reg;
    assign finished = finished_reg;
    assign success  = success_reg;

endmodule

// File: tb/tb_zero_out_checker.sv
// Directed bench for zero_out_checker with a 4-deep FIFO.
module tb_zero_out_checker;

    localparam int W  = 12;
    localparam int NO = 4;
    localparam int NE = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          exp_we;
    logic [4:0]    exp_addr;
    logic [W-1:0]  exp_data;
    logic [5:0]    exp_count;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          prog_done;
    logic          sink_valid;
    logic [W-1:0]  sink_data;
    logic          sink_ready;
    logic [15:0]   drained;
    logic          dropped;
    logic          finished;
    logic          success;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    zero_out_checker #(
        .MemoryElementWidth (W),
        .NOut               (NO),
        .NExpect            (NE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .exp_we     (exp_we),
        .exp_addr   (exp_addr),
        .exp_data   (exp_data),
        .exp_count  (exp_count),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .prog_done  (prog_done),
        .sink_valid (sink_valid),
        .sink_data  (sink_data),
        .sink_ready (sink_ready),
        .drained    (drained),
        .dropped    (dropped),
        .finished   (finished),
        .success    (success)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_table(input int addr, input int data);
        exp_we   = 1'b1;
        exp_addr = 5'(addr);
        exp_data = W'(data);
        tick();
        exp_we = 1'b0;
    endtask

    task automatic do_start(input int count);
        exp_count = 6'(count);
        start     = 1'b1;
        tick();
        start = 1'b0;
        $display("[TB] start exp_count=%0d", count);
    endtask

    task automatic push(input int data);
        out_valid = 1'b1;
        out_data  = W'(data);
        tick();
        out_valid = 1'b0;
        $display("[TB] push %0d", data);
    endtask

    task automatic finish_prog();
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (finished !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (finished !== 1'b1) begin
            fails++;
            $display("FAIL %s_finish: finished=%b want 1 after %0d cycles", name, finished, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tests++;
        if ({out_ready, sink_valid, finished, success, dropped} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00000",
                     {out_ready, sink_valid, finished, success, dropped});
        end
        tests++;
        if (drained !== 16'd0 || sink_data !== 12'd0) begin
            fails++;
            $display("FAIL reset_counts: drained=%0d sink_data=%0h want 0 0", drained, sink_data);
        end
    endtask

    task automatic test_pass();
        write_table(0, 1);
        write_table(1, 2);
        do_start(2);
        sink_ready = 1'b1;
        tests++;
        if (out_ready !== 1'b1) begin
            fails++;
            $display("FAIL pass_ready: out_ready=%b want 1", out_ready);
        end
        push(1);
        tests++;
        if (sink_valid !== 1'b1 || sink_data !== 12'd1) begin
            fails++;
            $display("FAIL pass_fwft: valid=%b data=%0d want 1 1", sink_valid, sink_data);
        end
        push(2);
        finish_prog();
        wait_done("pass");
        tests++;
        if (drained !== 16'd2 || success !== 1'b1 || sink_valid !== 1'b0) begin
            fails++;
            $display("FAIL pass_result: drained=%0d success=%b valid=%b want 2 1 0",
                     drained, success, sink_valid);
        end
    endtask

    task automatic test_mismatch();
        do_start(2);
        push(1);
        push(3);
        finish_prog();
        wait_done("mismatch");
        tests++;
        if (drained !== 16'd2 || success !== 1'b0) begin
            fails++;
            $display("FAIL mismatch_result: drained=%0d success=%b want 2 0", drained, success);
        end
    endtask

    task automatic test_short_and_long();
        do_start(2);
        push(1);
        finish_prog();
        wait_done("short");
        tests++;
        if (drained !== 16'd1 || success !== 1'b0) begin
            fails++;
            $display("FAIL short_result: drained=%0d success=%b want 1 0", drained, success);
        end
        // Extra element past exp_count fails even though it matches the table.
        do_start(1);
        push(1);
        push(2);
        finish_prog();
        wait_done("long");
        tests++;
        if (drained !== 16'd2 || success !== 1'b0) begin
            fails++;
            $display("FAIL long_result: drained=%0d success=%b want 2 0", drained, success);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) write_table(i, 10 + i);
        sink_ready = 1'b0;
        do_start(4);
        for (int i = 0; i < 6; i++) begin
            out_valid = 1'b1;
            out_data  = W'(10 + i);
            tests++;
            if (out_ready !== (i < 4)) begin
                fails++;
                $display("FAIL full_ready%0d: out_ready=%b want %b", i, out_ready, (i < 4));
            end
            tick();
        end
        out_valid = 1'b0;
        tests++;
        if (dropped !== 1'b1) begin
            fails++;
            $display("FAIL full_dropped: dropped=%b want 1", dropped);
        end
        sink_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (sink_valid !== 1'b1 || sink_data !== W'(10 + i)) begin
                fails++;
                $display("FAIL full_order%0d: valid=%b data=%0d want 1 %0d", i, sink_valid, sink_data, 10 + i);
            end
            tick();
        end
        finish_prog();
        wait_done("full");
        tests++;
        if (drained !== 16'd4 || success !== 1'b0) begin
            fails++;
            $display("FAIL full_result: drained=%0d success=%b want 4 0", drained, success);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) write_table(i, 20 + i);
        sink_ready = 1'b0;
        do_start(12);
        push(20);
        push(21);
        sink_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            out_valid = 1'b1;
            out_data  = W'(22 + i);
            tests++;
            if (sink_valid !== 1'b1 || out_ready !== 1'b1 || sink_data !== W'(20 + i)) begin
                fails++;
                $display("FAIL b2b_step%0d: valid=%b ready=%b data=%0d want 1 1 %0d",
                         i, sink_valid, out_ready, sink_data, 20 + i);
            end
            tick();
        end
        out_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (sink_valid !== 1'b1 || sink_data !== W'(30 + i)) begin
                fails++;
                $display("FAIL b2b_tail%0d: valid=%b data=%0d want 1 %0d", i, sink_valid, sink_data, 30 + i);
            end
            tick();
        end
        finish_prog();
        wait_done("b2b");
        tests++;
        if (drained !== 16'd12 || success !== 1'b1) begin
            fails++;
            $display("FAIL b2b_result: drained=%0d success=%b want 12 1", drained, success);
        end
    endtask

    task automatic test_reset_in_drain();
        for (int i = 0; i < 3; i++) write_table(i, 5 + i);
        sink_ready = 1'b0;
        do_start(3);
        push(5);
        push(6);
        push(7);
        finish_prog();
        tests++;
        if (sink_valid !== 1'b1 || out_ready !== 1'b0) begin
            fails++;
            $display("FAIL drain_state: valid=%b ready=%b want 1 0", sink_valid, out_ready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (sink_valid !== 1'b0 || drained !== 16'd0 || finished !== 1'b0 || sink_data !== 12'd0) begin
            fails++;
            $display("FAIL drain_reset: valid=%b drained=%0d finished=%b data=%0d want 0 0 0 0",
                     sink_valid, drained, finished, sink_data);
        end
        do_start(3);
        sink_ready = 1'b1;
        // Table writes while running must be ignored.
        write_table(0, 99);
        push(5);
        push(6);
        push(7);
        finish_prog();
        wait_done("rerun");
        tests++;
        if (drained !== 16'd3 || success !== 1'b1 || dropped !== 1'b0) begin
            fails++;
            $display("FAIL rerun_result: drained=%0d success=%b dropped=%b want 3 1 0",
                     drained, success, dropped);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        exp_we     = 1'b0;
        exp_addr   = '0;
        exp_data   = '0;
        exp_count  = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        prog_done  = 1'b0;
        sink_ready = 1'b0;
        test_reset();
        test_pass();
        test_mismatch();
        test_short_and_long();
        test_full();
        test_back_to_back();
        test_reset_in_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
